// File: rtl/demux_3_output_buffered.sv
// demux_3_output_buffered: registered 1-to-3 demux with per-channel one-entry holding slot and valid/ready handshake
// Invalid select (11) is always accepted, dropped, flagged for one cycle and counted (saturating).
module demux_3_output_buffered #(
    parameter int WORD_LENGTH = 32,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] in_data,
    input  logic [1:0]             in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WORD_LENGTH-1:0] out1_data,
    output logic                   out1_valid,
    input  logic                   out1_ready,
    output logic [WORD_LENGTH-1:0] out2_data,
    output logic                   out2_valid,
    input  logic                   out2_ready,
    output logic [WORD_LENGTH-1:0] out3_data,
    output logic                   out3_valid,
    input  logic                   out3_ready,
    output logic                   err_sel,
    output logic [CNT_WIDTH-1:0]   drop_count
);
    logic [WORD_LENGTH-1:0] r_data [3];
    logic [2:0]             r_valid;
    logic                   r_err;
    logic [CNT_WIDTH-1:0]   r_drop;
    logic [2:0]             w_out_ready;
    logic [3:0]             w_slot_ready;
    logic                   w_fire;
    logic                   w_drop;

    assign w_out_ready  = {out3_ready, out2_ready, out1_ready};
    // Slot 3 stands for the invalid select, which is always accepted.
    assign w_slot_ready = {1'b1, ~r_valid | w_out_ready};
    assign in_ready     = w_slot_ready[in_sel];
    assign w_fire       = in_valid & in_ready;
    assign w_drop       = w_fire & (in_sel == 2'b11);

    for (genvar g = 0; g < 3; g++) begin : g_ch
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[g] <= 1'b0;
                r_data[g]  <= '0;
            end else if (w_fire && in_sel == 2'(g)) begin
                r_valid[g] <= 1'b1;
                r_data[g]  <= in_data;
            end else if (r_valid[g] && w_out_ready[g]) begin
                r_valid[g] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_drop <= '0;
        end else begin
            r_err <= w_drop;
            if (w_drop && r_drop != '1)
                r_drop <= r_drop + 1'b1;
        end
    end

    assign out1_data  = r_data[0];
    assign out2_data  = r_data[1];
    assign out3_data  = r_data[2];
    assign out1_valid = r_valid[0];
    assign out2_valid = r_valid[1];
    assign out3_valid = r_valid[2];
    assign err_sel    = r_err;
    assign drop_count = r_drop;
endmodule

// File: tb/tb_demux_3_output_buffered.sv
// tb_demux_3_output_buffered: directed plus random stimulus against a per-channel queue scoreboard
module tb_demux_3_output_buffered;
    localparam int W = 32;
    localparam int C = 2;

    logic          clk = 0;
    logic          rst = 1;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_sel = '0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [2:0]    ordy = 3'b111;
    logic [W-1:0]  od [3];
    logic [2:0]    ov;
    logic          err_sel;
    logic [C-1:0]  drop_count;

    int checks = 0;
    int failures = 0;

    logic [W-1:0]  q [3][$];
    logic [W-1:0]  exp_data [3];
    logic          exp_err = 0;
    int            exp_drop = 0;
    bit            model_ok = 0;

    demux_3_output_buffered #(.WORD_LENGTH(W), .CNT_WIDTH(C)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out1_data(od[0]), .out1_valid(ov[0]), .out1_ready(ordy[0]),
        .out2_data(od[1]), .out2_valid(ov[1]), .out2_ready(ordy[1]),
        .out3_data(od[2]), .out3_valid(ov[2]), .out3_ready(ordy[2]),
        .err_sel(err_sel), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Scoreboard monitor: compares outputs against the model, then advances the model by this edge's transfers.
    always @(negedge clk) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) begin
                q[n].delete();
                exp_data[n] = '0;
            end
            exp_err  = 0;
            exp_drop = 0;
            model_ok = 1;
        end else if (model_ok) begin
            logic exp_rdy;
            logic [W-1:0] head;
            for (int n = 0; n < 3; n++) begin
                chk($sformatf("out%0d_valid", n + 1), W'(ov[n]), W'(q[n].size() != 0));
                chk($sformatf("out%0d_data", n + 1), od[n], exp_data[n]);
            end
            chk("err_sel", W'(err_sel), W'(exp_err));
            chk("drop_count", W'(drop_count), W'(exp_drop));
            if (in_sel == 2'b11) exp_rdy = 1;
            else exp_rdy = (q[in_sel].size() == 0) || ordy[in_sel];
            chk("in_ready", W'(in_ready), W'(exp_rdy));
            for (int n = 0; n < 3; n++)
                if (q[n].size() != 0 && ordy[n]) begin
                    head = q[n].pop_front();
                    chk($sformatf("pop%0d", n + 1), od[n], head);
                end
            exp_err = in_valid && in_sel == 2'b11;
            if (in_valid && exp_rdy && in_sel != 2'b11) begin
                q[in_sel].push_back(in_data);
                exp_data[in_sel] = in_data;
            end
            if (exp_err && exp_drop < (1 << C) - 1) exp_drop++;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [1:0] s);
        int n = 0;
        logic acc;
        in_data = d; in_sel = s; in_valid = 1;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 200);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout got=0 exp=1 data=%h", d);
        end
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        idle(2);
        send(32'h11111111, 2'b00);
        send(32'h22222222, 2'b01);
        send(32'h33333333, 2'b10);
        idle(2);
        ordy = 3'b110;
        fork
            begin send(32'hA5A5A5A5, 2'b00); send(32'h5A5A5A5A, 2'b00); end
            begin idle(5); ordy[0] = 1; end
        join
        idle(2);
        ordy = 3'b110;
        send(32'h0BADF00D, 2'b00);
        send(32'hDEADBEEF, 2'b10);
        idle(3);
        ordy = 3'b111;
        idle(2);
        ordy[1] = 0;
        send(32'h1, 2'b01);
        ordy[1] = 1;
        send(32'h2, 2'b01);
        idle(2);
        repeat (5) send($urandom, 2'b11);
        idle(3);
        ordy = 3'b000;
        send(32'hAAAA0001, 2'b00);
        send(32'hAAAA0002, 2'b01);
        send(32'hAAAA0003, 2'b10);
        in_data = 32'hCAFEF00D; in_sel = 2'b00; in_valid = 1; rst = 1;
        idle(1);
        rst = 0; in_valid = 0; ordy = 3'b111;
        idle(3);
        repeat (400) begin
            logic acc;
            @(negedge clk); acc = in_valid && in_ready;
            @(posedge clk); #1;
            ordy = 3'($urandom);
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_sel   = 2'($urandom);
                in_data  = $urandom;
            end
        end
        in_valid = 0; ordy = 3'b111;
        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_3_output_buffered.md
Name: demux_3_output_buffered

Overview:
- Registered 1-to-3 demultiplexer: steers one WORD_LENGTH-bit input stream to one of three output channels.
- Sel encoding matches the 3-input select mux: 00 -> out1, 01 -> out2, 10 -> out3, 11 -> invalid.
- Each output channel has a one-entry holding register and a valid/ready handshake.
- Sits between a producer stage and three consumer stages that can stall independently.
- Invalid selects are dropped, flagged with a pulse and counted.

Parameters:
WORD_LENGTH, 32, data width of input and every output.
CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_data  input  WORD_LENGTH  input word.
in_sel  input  2  destination select (00/01/10 valid, 11 invalid).
in_valid  input  1  input word present.
in_ready  output  1  block accepts the input this cycle (combinational).
out1_data  output  WORD_LENGTH  channel 1 held word.
out1_valid  output  1  channel 1 holds a word.
out1_ready  input  1  channel 1 consumer accepts.
out2_data  output  WORD_LENGTH  channel 2 held word.
out2_valid  output  1  channel 2 holds a word.
out2_ready  input  1  channel 2 consumer accepts.
out3_data  output  WORD_LENGTH  channel 3 held word.
out3_valid  output  1  channel 3 holds a word.
out3_ready  input  1  channel 3 consumer accepts.
err_sel  output  1  one-cycle pulse when an invalid-select word is dropped.
drop_count  output  CNT_WIDTH  number of dropped words; saturates.

Behaviour:
- Reset (rst=1 at an edge):
  - All outN_valid=0 and all outN_data=0.
  - err_sel=0 and drop_count=0.
  - Reset overrides any transfer in the same cycle; a word in flight is lost and not counted.
- Per-channel state: one holding register. Channel N is empty (outN_valid=0) or full (outN_valid=1).
- Input accept, in_fire = in_valid & in_ready:
  - in_ready for sel 00/01/10 = !outN_valid | outN_ready, where N is the selected channel. Pass-through when the slot frees in the same cycle.
  - in_ready for sel 11 = 1. The word is always accepted and discarded.
  - in_ready depends combinationally on in_sel and on the selected channel's ready. The producer must hold in_data and in_sel stable while in_valid=1 and in_ready=0.
- Output pop: outN_fire = outN_valid & outN_ready. Channels pop independently; several channels may pop in the same cycle.
- Next state for channel N:
  - in_fire to N: outN_data <= in_data and outN_valid <= 1, whether or not N pops this cycle.
  - Else if outN_fire: outN_valid <= 0. outN_data keeps its last value.
  - Else: hold.
- Latency:
  - A word accepted at edge k appears on outN at edge k (visible in cycle k+1). One cycle of latency.
  - Full throughput of 1 word/cycle per channel while its consumer holds ready=1.
- Stability: while outN_valid=1 and outN_ready=0, outN_data and outN_valid must not change.
- Ordering:
  - Words to the same channel are delivered in input order.
  - There is no ordering guarantee across channels.
- Non-selected channels: unaffected by the input. A full non-selected channel does not block the input.
- Invalid select (sel=11 with in_valid=1):
  - No output channel changes.
  - err_sel=1 for exactly the following cycle (registered), then returns to 0.
  - drop_count increments by 1, saturating at 2^CNT_WIDTH-1 with no wrap.
  - Back-to-back invalid words keep err_sel high continuously and count each word.
- err_sel is 0 in any cycle whose previous edge had no invalid-select fire.
- The block never produces X on any output after reset, even when in_sel is 11 with in_valid=0.

Test Plan:
1. Reset and pass-through:
   - Stimulus: assert rst 2 cycles, then send 0x11111111 sel=00, 0x22222222 sel=01, 0x33333333 sel=10 on consecutive cycles, all readies=1.
   - Response: each word appears on out1/out2/out3 one cycle after acceptance; in_ready=1 throughout; all other outputs 0 after reset.
2. Backpressure:
   - Stimulus: out1_ready=0, send 0xA5A5A5A5 sel=00, then 0x5A5A5A5A sel=00.
   - Response: the first word is held on out1 stable; in_ready=0 for the second word until out1_ready=1; the second word follows on the next cycle; no loss or duplication.
3. Independent channels:
   - Stimulus: out1 full and stalled, send 0xDEADBEEF sel=10.
   - Response: accepted immediately and appears on out3; out1 is unchanged.
4. Simultaneous pop and push:
   - Stimulus: out2 full with 0x1, out2_ready=1, input 0x2 sel=01 in the same cycle.
   - Response: in_ready=1; out2_data becomes 0x2 with out2_valid staying 1; 0x1 is consumed exactly once.
5. Invalid select and saturation:
   - Stimulus: with CNT_WIDTH=2, send 5 back-to-back words with sel=11.
   - Response: err_sel high for 5 cycles; drop_count goes 1, 2, 3, 3, 3; no outN_valid rises.
6. Reset mid-operation:
   - Stimulus: fill all three channels with readies=0, then assert rst for 1 cycle while in_valid=1 sel=00.
   - Response: all valids=0, data=0, drop_count=0 after the edge; the in-flight word does not appear.
